// File: rtl/uart_rx_if.sv
`default_nettype none
// ============================================================================
// Module   : uart_rx_if
// Desc     : Serial input, parity mode and received-word bundle for uart_rx.
// Revision : 1.0 - initial release
// ============================================================================
interface uart_rx_if #(
    parameter int DATA_WIDTH = 8
);
    logic                  rx_in;
    logic [31:0]           parity_type;
    logic [DATA_WIDTH-1:0] data_out;
    logic                  data_valid;
    logic                  parity_err;
    logic                  frame_err;
    logic                  busy;

    modport master (
        output rx_in, parity_type,
        input  data_out, data_valid, parity_err, frame_err, busy
    );

    modport slave (
        input  rx_in, parity_type,
        output data_out, data_valid, parity_err, frame_err, busy
    );
endinterface
`default_nettype wire

// File: rtl/uart_rx.sv
`default_nettype none
// ============================================================================
// Module   : uart_rx
// Desc     : Oversampling UART receiver, LSB first, optional parity, stop check.
// Revision : 1.0 - initial release
// ============================================================================
module uart_rx #(
    parameter int DATA_WIDTH   = 8,
    parameter int CLKS_PER_BIT = 868
) (
    input  logic     clk,
    input  logic     rst,
    uart_rx_if.slave bus
);
    localparam int c_CNT_W = $clog2(CLKS_PER_BIT);
    localparam int c_BIT_W = $clog2(DATA_WIDTH + 1);
    localparam logic [c_CNT_W-1:0] c_HALF_M1  = c_CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [c_CNT_W-1:0] c_FULL_M1  = c_CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [c_BIT_W-1:0] c_LAST_BIT = c_BIT_W'(DATA_WIDTH - 1);

    localparam logic [2:0] c_PAR_NONE  = 3'd0;
    localparam logic [2:0] c_PAR_EVEN  = 3'd1;
    localparam logic [2:0] c_PAR_ODD   = 3'd2;
    localparam logic [2:0] c_PAR_MARK  = 3'd3;
    localparam logic [2:0] c_PAR_SPACE = 3'd4;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
        S_PARITY = 3'd3,
        S_STOP   = 3'd4,
        S_BREAK  = 3'd5
    } state_t;

    state_t                r_state;
    state_t                w_state_next;
    logic                  r_rx_meta;
    logic                  r_rx_s;
    logic [c_CNT_W-1:0]    r_cnt;
    logic [c_BIT_W-1:0]    r_bit_cnt;
    logic [2:0]            r_par_mode;
    logic [DATA_WIDTH-1:0] r_shreg;
    logic [DATA_WIDTH-1:0] r_data;
    logic                  r_perr;
    logic                  r_valid;
    logic                  r_parity_err;
    logic                  r_frame_err;
    logic                  w_tick;
    logic                  w_par_exp;
    logic [2:0]            w_par_mode;

    // Out-of-range parity codes collapse to "none" before latching.
    assign w_par_mode = (bus.parity_type <= 32'd4) ? bus.parity_type[2:0] : c_PAR_NONE;
    assign w_tick     = (r_cnt == '0);

    always_comb begin
        w_par_exp = 1'b0;
        case (r_par_mode)
            c_PAR_EVEN:  w_par_exp = ^r_shreg;
            c_PAR_ODD:   w_par_exp = ~^r_shreg;
            c_PAR_MARK:  w_par_exp = 1'b1;
            c_PAR_SPACE: w_par_exp = 1'b0;
            default:     w_par_exp = 1'b0;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE:   if (!r_rx_s) w_state_next = S_START;
            S_START:  if (w_tick) w_state_next = r_rx_s ? S_IDLE : S_DATA;
            S_DATA:   if (w_tick && (r_bit_cnt == c_LAST_BIT))
                          w_state_next = (r_par_mode != c_PAR_NONE) ? S_PARITY : S_STOP;
            S_PARITY: if (w_tick) w_state_next = S_STOP;
            // Leaving mid stop bit lets the next start edge be caught without a gap.
            S_STOP:   if (w_tick) w_state_next = r_rx_s ? S_IDLE : S_BREAK;
            S_BREAK:  if (r_rx_s) w_state_next = S_IDLE;
            default:  w_state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rx_meta    <= 1'b1;
            r_rx_s       <= 1'b1;
            r_cnt        <= '0;
            r_bit_cnt    <= '0;
            r_par_mode   <= c_PAR_NONE;
            r_shreg      <= '0;
            r_perr       <= 1'b0;
            r_data       <= '0;
            r_valid      <= 1'b0;
            r_parity_err <= 1'b0;
            r_frame_err  <= 1'b0;
        end else begin
            r_rx_meta <= bus.rx_in;
            r_rx_s    <= r_rx_meta;
            r_valid   <= 1'b0;

            // Counter sits at half a bit in IDLE so the first tick lands mid start bit.
            if (r_state == S_IDLE) begin
                r_cnt     <= c_HALF_M1;
                r_bit_cnt <= '0;
                if (!r_rx_s) begin
                    r_par_mode <= w_par_mode;
                    r_perr     <= 1'b0;
                end
            end else if (w_tick) begin
                r_cnt <= c_FULL_M1;
            end else begin
                r_cnt <= r_cnt - 1'b1;
            end

            if (w_tick) begin
                case (r_state)
                    S_DATA: begin
                        r_shreg   <= {r_rx_s, r_shreg[DATA_WIDTH-1:1]};
                        r_bit_cnt <= r_bit_cnt + 1'b1;
                    end
                    S_PARITY: r_perr <= (r_rx_s != w_par_exp);
                    S_STOP: begin
                        r_valid      <= 1'b1;
                        r_data       <= r_shreg;
                        r_parity_err <= r_perr;
                        r_frame_err  <= ~r_rx_s;
                    end
                    default: ;
                endcase
            end
        end
    end

    assign bus.data_out   = r_data;
    assign bus.data_valid = r_valid;
    assign bus.parity_err = r_parity_err;
    assign bus.frame_err  = r_frame_err;
    assign bus.busy       = (r_state != S_IDLE);
endmodule
`default_nettype wire

// File: tb/tb_uart_rx.sv
`default_nettype none
// ============================================================================
// Module   : tb_uart_rx
// Desc     : Directed self-checking bench for uart_rx at 16 clocks per bit.
// Revision : 1.0 - initial release
// ============================================================================
module tb_uart_rx;
    localparam int c_CPB = 16;

    logic clk;
    logic rst;
    int   errors;
    int   checks;

    int         n_strobe;
    int         n_double;
    logic       prev_valid;
    logic [7:0] cap_data [0:63];
    logic       cap_perr [0:63];
    logic       cap_ferr [0:63];

    uart_rx_if #(.DATA_WIDTH(8)) bus ();

    uart_rx #(
        .DATA_WIDTH  (8),
        .CLKS_PER_BIT(c_CPB)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Strobe recorder: sampled on the falling edge, away from the active edge.
    always @(negedge clk) begin
        if (bus.data_valid === 1'b1) begin
            cap_data[n_strobe % 64] = bus.data_out;
            cap_perr[n_strobe % 64] = bus.parity_err;
            cap_ferr[n_strobe % 64] = bus.frame_err;
            n_strobe = n_strobe + 1;
            if (prev_valid === 1'b1) n_double = n_double + 1;
        end
        prev_valid = bus.data_valid;
    end

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_bit(input logic b);
        bus.rx_in = b;
        cyc(c_CPB);
    endtask

    // chg_pt >= 0 rewrites parity_type right after the start bit.
    task automatic send_frame(input logic [7:0] d, input int pt, input int chg_pt,
                              input logic pbit, input logic stop);
        bus.parity_type = pt;
        send_bit(1'b0);
        if (chg_pt >= 0) bus.parity_type = chg_pt;
        for (int i = 0; i < 8; i++) send_bit(d[i]);
        if (pt >= 1 && pt <= 4) send_bit(pbit);
        send_bit(stop);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.rx_in = 1'b1;
        bus.parity_type = 32'd0;
        cyc(3);
        if (bus.data_out !== 8'h00) begin errors++; $display("FAIL reset_data: got %h want 00", bus.data_out); end
        checks++;
        if (bus.data_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", bus.data_valid); end
        checks++;
        if (bus.parity_err !== 1'b0 || bus.frame_err !== 1'b0) begin
            errors++; $display("FAIL reset_flags: got perr=%b ferr=%b want 0 0", bus.parity_err, bus.frame_err);
        end
        checks++;
        if (bus.busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", bus.busy); end
        checks++;
        rst = 1'b0;
        cyc(10);
    endtask

    task automatic test_even_parity();
        int s0;
        s0 = n_strobe;
        send_frame(8'hA5, 1, -1, 1'b0, 1'b1);
        cyc(4);
        if (n_strobe - s0 !== 1) begin errors++; $display("FAIL even_strobes: got %0d want 1", n_strobe - s0); end
        checks++;
        if (cap_data[s0 % 64] !== 8'hA5) begin errors++; $display("FAIL even_data: got %h want a5", cap_data[s0 % 64]); end
        checks++;
        if (cap_perr[s0 % 64] !== 1'b0 || cap_ferr[s0 % 64] !== 1'b0) begin
            errors++; $display("FAIL even_flags: got perr=%b ferr=%b want 0 0", cap_perr[s0 % 64], cap_ferr[s0 % 64]);
        end
        checks++;
        if (bus.data_out !== 8'hA5) begin errors++; $display("FAIL even_hold: got %h want a5", bus.data_out); end
        checks++;
    endtask

    task automatic test_odd_parity();
        int s0;
        s0 = n_strobe;
        send_frame(8'h3C, 2, -1, 1'b0, 1'b1);
        cyc(4);
        if (bus.data_out !== 8'h3C) begin errors++; $display("FAIL odd_bad_data: got %h want 3c", bus.data_out); end
        checks++;
        if (bus.parity_err !== 1'b1) begin errors++; $display("FAIL odd_bad_perr: got %b want 1", bus.parity_err); end
        checks++;
        send_frame(8'h3C, 2, -1, 1'b1, 1'b1);
        cyc(4);
        if (bus.parity_err !== 1'b0) begin errors++; $display("FAIL odd_good_perr: got %b want 0", bus.parity_err); end
        checks++;
        if (n_strobe - s0 !== 2) begin errors++; $display("FAIL odd_strobes: got %0d want 2", n_strobe - s0); end
        checks++;
    endtask

    task automatic test_frame_error();
        int s0;
        s0 = n_strobe;
        send_frame(8'h81, 0, -1, 1'b0, 1'b0);
        bus.rx_in = 1'b0;
        cyc(40);
        if (n_strobe - s0 !== 1) begin errors++; $display("FAIL ferr_strobes: got %0d want 1", n_strobe - s0); end
        checks++;
        if (bus.frame_err !== 1'b1 || bus.data_out !== 8'h81) begin
            errors++; $display("FAIL ferr_flag: got ferr=%b data=%h want 1 81", bus.frame_err, bus.data_out);
        end
        checks++;
        if (bus.parity_err !== 1'b0) begin errors++; $display("FAIL ferr_perr: got %b want 0", bus.parity_err); end
        checks++;
        if (bus.busy !== 1'b1) begin errors++; $display("FAIL ferr_busy_low: got %b want 1", bus.busy); end
        checks++;
        bus.rx_in = 1'b1;
        cyc(5);
        if (bus.busy !== 1'b0) begin errors++; $display("FAIL ferr_busy_release: got %b want 0", bus.busy); end
        checks++;
        cyc(40);
        if (n_strobe - s0 !== 1) begin errors++; $display("FAIL ferr_no_second: got %0d want 1", n_strobe - s0); end
        checks++;
    endtask

    task automatic test_glitch();
        int s0;
        s0 = n_strobe;
        bus.rx_in = 1'b0;
        cyc(4);
        bus.rx_in = 1'b1;
        cyc(1);
        if (bus.busy !== 1'b1) begin errors++; $display("FAIL glitch_busy_rise: got %b want 1", bus.busy); end
        checks++;
        cyc(7);
        if (bus.busy !== 1'b0) begin errors++; $display("FAIL glitch_busy_fall: got %b want 0", bus.busy); end
        checks++;
        cyc(30);
        if (n_strobe - s0 !== 0) begin errors++; $display("FAIL glitch_strobes: got %0d want 0", n_strobe - s0); end
        checks++;
    endtask

    task automatic test_back_to_back();
        int s0;
        s0 = n_strobe;
        send_frame(8'h00, 3, -1, 1'b1, 1'b1);
        // Second frame switches to none after its start bit; the latched space mode must win.
        send_frame(8'hFF, 4, 0, 1'b1, 1'b1);
        cyc(4);
        if (n_strobe - s0 !== 2) begin errors++; $display("FAIL b2b_strobes: got %0d want 2", n_strobe - s0); end
        checks++;
        if (cap_data[s0 % 64] !== 8'h00 || cap_perr[s0 % 64] !== 1'b0) begin
            errors++; $display("FAIL b2b_mark: got data=%h perr=%b want 00 0", cap_data[s0 % 64], cap_perr[s0 % 64]);
        end
        checks++;
        if (cap_data[(s0 + 1) % 64] !== 8'hFF || cap_perr[(s0 + 1) % 64] !== 1'b1) begin
            errors++; $display("FAIL b2b_space: got data=%h perr=%b want ff 1",
                               cap_data[(s0 + 1) % 64], cap_perr[(s0 + 1) % 64]);
        end
        checks++;
        if (cap_ferr[(s0 + 1) % 64] !== 1'b0) begin
            errors++; $display("FAIL b2b_ferr: got %b want 0", cap_ferr[(s0 + 1) % 64]);
        end
        checks++;
        cyc(20);
    endtask

    task automatic test_reset_mid_frame();
        logic [7:0] d;
        int s0;
        d = 8'h55;
        s0 = n_strobe;
        bus.parity_type = 32'd0;
        send_bit(1'b0);
        for (int i = 0; i < 3; i++) send_bit(d[i]);
        bus.rx_in = d[3];
        cyc(8);
        if (bus.busy !== 1'b1) begin errors++; $display("FAIL midrst_busy_before: got %b want 1", bus.busy); end
        checks++;
        rst = 1'b1;
        bus.rx_in = 1'b1;
        #1;
        if (bus.data_out !== 8'h00 || bus.busy !== 1'b0) begin
            errors++; $display("FAIL midrst_outputs: got data=%h busy=%b want 00 0", bus.data_out, bus.busy);
        end
        checks++;
        if (bus.parity_err !== 1'b0 || bus.frame_err !== 1'b0 || bus.data_valid !== 1'b0) begin
            errors++; $display("FAIL midrst_flags: got perr=%b ferr=%b valid=%b want 0 0 0",
                               bus.parity_err, bus.frame_err, bus.data_valid);
        end
        checks++;
        cyc(2);
        rst = 1'b0;
        cyc(40);
        if (n_strobe - s0 !== 0) begin errors++; $display("FAIL midrst_no_strobe: got %0d want 0", n_strobe - s0); end
        checks++;
        send_frame(8'h12, 0, -1, 1'b0, 1'b1);
        cyc(4);
        if (n_strobe - s0 !== 1 || bus.data_out !== 8'h12) begin
            errors++; $display("FAIL midrst_recover: got strobes=%0d data=%h want 1 12", n_strobe - s0, bus.data_out);
        end
        checks++;
        if (bus.parity_err !== 1'b0 || bus.frame_err !== 1'b0) begin
            errors++; $display("FAIL midrst_recover_flags: got perr=%b ferr=%b want 0 0", bus.parity_err, bus.frame_err);
        end
        checks++;
    endtask

    initial begin
        errors     = 0;
        checks     = 0;
        n_strobe   = 0;
        n_double   = 0;
        prev_valid = 1'b0;
        rst        = 1'b1;
        bus.rx_in  = 1'b1;
        bus.parity_type = 32'd0;
        @(posedge clk);
        #1;
        test_reset();
        test_even_parity();
        test_odd_parity();
        test_frame_error();
        test_glitch();
        test_back_to_back();
        test_reset_mid_frame();
        if (n_double !== 0) begin errors++; $display("FAIL valid_single_cycle: got %0d doubles want 0", n_double); end
        checks++;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
`default_nettype wire
